// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and address constants shared by the pipeline sequencer
package pipe_ctrl_pkg;
  localparam int INST_ADDR_W = 32;
  localparam logic [INST_ADDR_W-1:0] RESET_ADDR = 32'h0000_0000;
  typedef enum logic [1:0] {
    PC_IDLE  = 2'b00,
    PC_FLUSH = 2'b01,
    PC_DIV   = 2'b10,
    PC_BUS   = 2'b11
  } pc_state_e;
endpackage

// File: rtl/pipe_ctrl_cnt.sv
// pipe_ctrl_cnt: loadable down-counter; zero flags the cycle the count reaches 0
module pipe_ctrl_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic         zero
);
  logic [W-1:0] q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= din;
    else if (dec && q != '0) q <= q - W'(1);
  // true when this cycle's decrement lands on zero (or it is already there)
  assign zero = q == W'(dec);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: PC/if_id/id_ex sequencer for jumps, load-use, divide and bus holds; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int DIV_TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jump_flag_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic                   ld_hazard_i,
  input  logic                   div_start_i,
  input  logic                   div_done_i,
  input  logic                   bus_req_i,
  output logic                   jump_flag_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic                   hold_pc_o,
  output logic                   hold_if_o,
  output logic                   flush_if_o,
  output logic                   hold_flag_o,
  output logic                   bus_grant_o,
  output logic                   div_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            flush_cnt_o
`endif
);
  localparam int WW = DIV_TIMEOUT > 0 ? $clog2(DIV_TIMEOUT + 1) : 1;
  pc_state_e st, nxt;
  logic grant, f_load, f_dec, f_zero, w_load, w_dec, w_zero;
  pipe_ctrl_cnt #(.W(3)) u_flush (
    .clk(clk), .rst_n(rst_n), .load(f_load), .dec(f_dec),
    .din(3'(FLUSH_CYCLES - 1)), .zero(f_zero)
  );
  // watchdog counts DIV_TIMEOUT down; zero lands on the DIV_TIMEOUT-th wait cycle
  pipe_ctrl_cnt #(.W(WW)) u_wd (
    .clk(clk), .rst_n(rst_n), .load(w_load), .dec(w_dec),
    .din(WW'(DIV_TIMEOUT)), .zero(w_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= PC_IDLE;
      grant <= 1'b0;
    end else begin
      st    <= nxt;
      grant <= nxt == PC_BUS;
    end
  assign bus_grant_o = grant;
  always_comb begin
    nxt           = st;
    jump_flag_o   = 1'b0;
    jump_addr_o   = RESET_ADDR;
    hold_pc_o     = 1'b0;
    hold_if_o     = 1'b0;
    flush_if_o    = 1'b0;
    hold_flag_o   = 1'b0;
    div_timeout_o = 1'b0;
    f_load        = 1'b0;
    f_dec         = 1'b0;
    w_load        = 1'b0;
    w_dec         = 1'b0;
    case (st)
      PC_IDLE:
        if (jump_flag_i) begin
          jump_flag_o = 1'b1;
          jump_addr_o = jump_addr_i;
          flush_if_o  = 1'b1;
          hold_flag_o = 1'b1;
          f_load      = 1'b1;
          nxt         = FLUSH_CYCLES > 1 ? PC_FLUSH : PC_IDLE;
        end else if (div_start_i) begin
          w_load = 1'b1;
          nxt    = PC_DIV;
        end else if (bus_req_i) begin
          nxt = PC_BUS;
        end else if (ld_hazard_i) begin
          hold_pc_o   = 1'b1;
          hold_if_o   = 1'b1;
          hold_flag_o = 1'b1;
        end
      PC_FLUSH: begin
        flush_if_o  = 1'b1;
        hold_flag_o = 1'b1;
        f_dec       = 1'b1;
        nxt         = f_zero ? PC_IDLE : PC_FLUSH;
      end
      PC_DIV: begin
        hold_pc_o   = 1'b1;
        hold_if_o   = 1'b1;
        hold_flag_o = 1'b1;
        w_dec       = 1'b1;
        // done beats a coincident watchdog expiry
        div_timeout_o = !div_done_i && DIV_TIMEOUT != 0 && w_zero;
        nxt           = div_done_i || div_timeout_o ? PC_IDLE : PC_DIV;
      end
      default: begin
        hold_pc_o   = 1'b1;
        hold_if_o   = 1'b1;
        hold_flag_o = 1'b1;
        nxt         = bus_req_i ? PC_BUS : PC_IDLE;
      end
    endcase
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      stall_cnt_o <= stall_cnt_o + 32'(hold_pc_o && stall_cnt_o != '1);
      flush_cnt_o <= flush_cnt_o + 32'(flush_if_o && flush_cnt_o != '1);
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl with FLUSH_CYCLES=2, DIV_TIMEOUT=64 (PIPE_CTRL_PERF_EN optional)
module tb_pipe_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic jump_flag_i = 1'b0, ld_hazard_i = 1'b0, div_start_i = 1'b0, div_done_i = 1'b0, bus_req_i = 1'b0;
  logic [31:0] jump_addr_i = '0, jump_addr_o;
  logic jump_flag_o, hold_pc_o, hold_if_o, flush_if_o, hold_flag_o, bus_grant_o, div_timeout_o;
  int total = 0, bad = 0;
  int exp_stall = 0, exp_flush = 0;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif
  pipe_ctrl #(.FLUSH_CYCLES(2), .DIV_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ld_hazard_i(ld_hazard_i), .div_start_i(div_start_i), .div_done_i(div_done_i),
    .bus_req_i(bus_req_i), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .hold_pc_o(hold_pc_o), .hold_if_o(hold_if_o), .flush_if_o(flush_if_o),
    .hold_flag_o(hold_flag_o), .bus_grant_o(bus_grant_o), .div_timeout_o(div_timeout_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  // {jump_flag, hold_pc, hold_if, flush_if, hold_flag, bus_grant, div_timeout}
  localparam logic [6:0] O_IDLE = 7'b0000000, O_JUMP = 7'b1001100, O_FLUSH = 7'b0001100,
                         O_HOLD = 7'b0110100, O_TMO = 7'b0110101, O_BUS = 7'b0110110;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic look(input string tag, input logic [6:0] e, input logic [31:0] ea);
    chk(tag, {25'b0, jump_flag_o, hold_pc_o, hold_if_o, flush_if_o, hold_flag_o, bus_grant_o, div_timeout_o}, {25'b0, e});
    chk({tag, "_addr"}, jump_addr_o, ea);
  endtask
  task automatic step(input string tag, input logic j, input logic [31:0] ja, input logic ld,
                      input logic ds, input logic dd, input logic br, input logic [6:0] e,
                      input logic [31:0] ea);
    @(negedge clk);
    jump_flag_i = j; jump_addr_i = ja; ld_hazard_i = ld;
    div_start_i = ds; div_done_i = dd; bus_req_i = br;
    #1;
    look(tag, e, ea);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, "_stall_cnt"}, stall_cnt_o, 32'(exp_stall));
    chk({tag, "_flush_cnt"}, flush_cnt_o, 32'(exp_flush));
`endif
    exp_stall += int'(e[5]);
    exp_flush += int'(e[3]);
  endtask
  task automatic reset_now(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 look(tag, O_IDLE, 32'h0);
    exp_stall = 0;
    exp_flush = 0;
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, "_stall_cnt"}, stall_cnt_o, 32'h0);
    chk({tag, "_flush_cnt"}, flush_cnt_o, 32'h0);
`endif
    bus_req_i = 1'b0; div_start_i = 1'b0; div_done_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #1 look("reset", O_IDLE, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step("idle", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // taken jump: zero-latency redirect, two flush cycles
    step("jump", 1, 32'h100, 0, 0, 0, 0, O_JUMP, 32'h100);
    step("flush1", 0, 0, 0, 0, 0, 0, O_FLUSH, 32'h0);
    step("jump_done", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // divide finishing on the 11th wait cycle
    step("div_start", 0, 0, 0, 1, 0, 0, O_IDLE, 32'h0);
    for (int i = 1; i <= 11; i++) step("div_wait", 0, 0, 0, 0, i == 11, 0, O_HOLD, 32'h0);
    step("div_release", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // watchdog expiry on the 64th wait cycle
    step("wd_start", 0, 0, 0, 1, 0, 0, O_IDLE, 32'h0);
    for (int i = 1; i <= 64; i++) step("wd_wait", 0, 0, 0, 0, 0, 0, i == 64 ? O_TMO : O_HOLD, 32'h0);
    step("wd_release", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // done coinciding with expiry suppresses the timeout pulse
    step("wdd_start", 0, 0, 0, 1, 0, 0, O_IDLE, 32'h0);
    for (int i = 1; i <= 64; i++) step("wdd_wait", 0, 0, 0, 0, i == 64, 0, O_HOLD, 32'h0);
    step("wdd_release", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // bus request held for 5 cycles
    step("bus_req", 0, 0, 0, 0, 0, 1, O_IDLE, 32'h0);
    for (int i = 1; i <= 4; i++) step("bus_grant", 0, 0, 0, 0, 0, 1, O_BUS, 32'h0);
    step("bus_last", 0, 0, 0, 0, 0, 0, O_BUS, 32'h0);
    step("bus_release", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // jump beats a simultaneous bus request, which waits out the flush
    step("jb_jump", 1, 32'h200, 0, 0, 0, 1, O_JUMP, 32'h200);
    step("jb_flush", 0, 0, 0, 0, 0, 1, O_FLUSH, 32'h0);
    step("jb_req", 0, 0, 0, 0, 0, 1, O_IDLE, 32'h0);
    step("jb_grant", 0, 0, 0, 0, 0, 0, O_BUS, 32'h0);
    step("jb_idle", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // load-use: single bubble
    step("ld_hazard", 0, 0, 1, 0, 0, 0, O_HOLD, 32'h0);
    step("ld_after", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // priorities inside IDLE
    step("pri_jump_ld", 1, 32'h300, 1, 1, 0, 1, O_JUMP, 32'h300);
    step("pri_flush", 0, 0, 0, 0, 0, 0, O_FLUSH, 32'h0);
    step("pri_div_ld", 0, 0, 1, 1, 0, 1, O_IDLE, 32'h0);
    step("pri_div_wait", 0, 0, 0, 0, 1, 1, O_HOLD, 32'h0);
    step("pri_bus_ld", 0, 0, 1, 0, 0, 1, O_IDLE, 32'h0);
    step("pri_bus", 0, 0, 0, 0, 0, 0, O_BUS, 32'h0);
    step("pri_idle", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    // asynchronous reset mid divide and mid grant
    step("rd_start", 0, 0, 0, 1, 0, 0, O_IDLE, 32'h0);
    step("rd_wait", 0, 0, 0, 0, 0, 0, O_HOLD, 32'h0);
    reset_now("rst_mid_div");
    step("rd_idle", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    step("rb_req", 0, 0, 0, 0, 0, 1, O_IDLE, 32'h0);
    step("rb_grant", 0, 0, 0, 0, 0, 1, O_BUS, 32'h0);
    reset_now("rst_mid_bus");
    step("rb_idle", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    step("final_ld", 0, 0, 1, 0, 0, 0, O_HOLD, 32'h0);
    step("final_idle", 0, 0, 0, 0, 0, 0, O_IDLE, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
